// File: rtl/fill_engine.sv
// fill_engine: fills an inclusive rectangle with one colour by issuing
// row-major pixel writes to a GPU, pacing them with GAP_CYCLES idle cycles.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_start, in_abort        fill request (IDLE only) / stop fill
//   in_x0/in_y0/in_x1/in_y1   rectangle corners, any order
//   in_color, in_overlay      pixel value and layer select
//   in_write_available        GPU ready for a write
//   out_write + out_px_data, out_column, out_row, out_image_overlay
//                             write strobe and its payload
//   out_busy, out_done        activity flag and completion pulse
module fill_engine #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_start,
    input  logic [5:0] in_x0,
    input  logic [5:0] in_y0,
    input  logic [5:0] in_x1,
    input  logic [5:0] in_y1,
    input  logic [7:0] in_color,
    input  logic       in_overlay,
    input  logic       in_abort,
    input  logic       in_write_available,
    output logic       out_write,
    output logic [7:0] out_px_data,
    output logic [5:0] out_column,
    output logic [5:0] out_row,
    output logic       out_image_overlay,
    output logic       out_busy,
    output logic       out_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [5:0] xmin_q, xmin_d;
    logic [5:0] xmax_q, xmax_d;
    logic [5:0] ymin_q, ymin_d;
    logic [5:0] ymax_q, ymax_d;
    logic [5:0] col_q, col_d;
    logic [5:0] row_q, row_d;
    logic [7:0] color_q, color_d;
    logic       ovl_q, ovl_d;
    logic       last_q, last_d;
    logic [3:0] gap_q, gap_d;

    always_comb begin
        state_d   = state_q;
        xmin_d    = xmin_q;
        xmax_d    = xmax_q;
        ymin_d    = ymin_q;
        ymax_d    = ymax_q;
        col_d     = col_q;
        row_d     = row_q;
        color_d   = color_q;
        ovl_d     = ovl_q;
        last_d    = last_q;
        gap_d     = gap_q;
        out_write = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    xmin_d  = (in_x0 < in_x1) ? in_x0 : in_x1;
                    xmax_d  = (in_x0 < in_x1) ? in_x1 : in_x0;
                    ymin_d  = (in_y0 < in_y1) ? in_y0 : in_y1;
                    ymax_d  = (in_y0 < in_y1) ? in_y1 : in_y0;
                    col_d   = (in_x0 < in_x1) ? in_x0 : in_x1;
                    row_d   = (in_y0 < in_y1) ? in_y0 : in_y1;
                    color_d = in_color;
                    ovl_d   = in_overlay;
                    last_d  = 1'b0;
                    gap_d   = 4'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (in_write_available) begin
                    out_write = 1'b1;
                    gap_d     = 4'd0;
                    // The final pixel leaves col/row parked on it, so the
                    // counters never step past xmax/ymax (no 63 wrap).
                    if (col_q == xmax_q) begin
                        if (row_q == ymax_q) begin
                            last_d = 1'b1;
                        end else begin
                            col_d = xmin_q;
                            row_d = row_q + 6'd1;
                        end
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                    state_d = in_abort ? S_DONE : S_GAP;
                end else if (in_abort) begin
                    state_d = S_DONE;
                end
            end
            S_GAP: begin
                if (in_abort) begin
                    state_d = S_DONE;
                end else if (gap_q == GAP_LAST) begin
                    state_d = last_q ? S_DONE : S_ISSUE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            color_q <= '0;
            ovl_q   <= 1'b0;
            last_q  <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            col_q   <= col_d;
            row_q   <= row_d;
            color_q <= color_d;
            ovl_q   <= ovl_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
        end
    end

    assign out_px_data       = color_q;
    assign out_column        = col_q;
    assign out_row           = row_q;
    assign out_image_overlay = ovl_q;
    assign out_busy          = (state_q != S_IDLE);
    assign out_done          = (state_q == S_DONE);

endmodule

// File: tb/tb_fill_engine.sv
// tb_fill_engine: table, hand-written and random fills of fill_engine,
// compared against a nested-loop rectangle model.
module tb_fill_engine;

    localparam int GAP = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_start;
    logic [5:0] in_x0, in_y0, in_x1, in_y1;
    logic [7:0] in_color;
    logic       in_overlay;
    logic       in_abort;
    logic       in_write_available;
    logic       out_write;
    logic [7:0] out_px_data;
    logic [5:0] out_column, out_row;
    logic       out_image_overlay;
    logic       out_busy;
    logic       out_done;

    fill_engine #(.GAP_CYCLES(GAP)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_start          (in_start),
        .in_x0             (in_x0),
        .in_y0             (in_y0),
        .in_x1             (in_x1),
        .in_y1             (in_y1),
        .in_color          (in_color),
        .in_overlay        (in_overlay),
        .in_abort          (in_abort),
        .in_write_available(in_write_available),
        .out_write         (out_write),
        .out_px_data       (out_px_data),
        .out_column        (out_column),
        .out_row           (out_row),
        .out_image_overlay (out_image_overlay),
        .out_busy          (out_busy),
        .out_done          (out_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int r;
        int d;
        int o;
        int cyc;
    } wr_t;

    typedef struct {
        int x0, y0, x1, y1;
        int color, ovl;
        int n, fc, fr, lc, lr;
    } vec_t;

    wr_t got[$];
    int  cyc = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_write)
            got.push_back('{int'(out_column), int'(out_row),
                            int'(out_px_data), int'(out_image_overlay), cyc});
        if (!rst && out_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input bit ok, input string name,
                       input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        chk(out_write == 0, {tag, "/write"}, out_write, 0);
        chk(out_done == 0, {tag, "/done"}, out_done, 0);
        chk(out_busy == 0, {tag, "/busy"}, out_busy, 0);
        chk(out_px_data == 0, {tag, "/data"}, out_px_data, 0);
        chk(out_column == 0, {tag, "/col"}, out_column, 0);
        chk(out_row == 0, {tag, "/row"}, out_row, 0);
        chk(out_image_overlay == 0, {tag, "/ovl"}, out_image_overlay, 0);
    endtask

    task automatic start_fill(input int x0, y0, x1, y1, color, ovl);
        in_x0 = 6'(x0); in_y0 = 6'(y0);
        in_x1 = 6'(x1); in_y1 = 6'(y1);
        in_color = 8'(color); in_overlay = ovl[0];
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
    endtask

    // Full fill with sequence, payload, pacing and handshake checks.
    task automatic run_fill(input int x0, y0, x1, y1, color, ovl,
                            input bit rnd, input int n, fc, fr, lc, lr,
                            input int inject, input string tag);
        int gb, db, budget, xl, xh, yl, yh, bad, k;
        int ec[$];
        int er[$];
        xl = (x0 < x1) ? x0 : x1;  xh = (x0 < x1) ? x1 : x0;
        yl = (y0 < y1) ? y0 : y1;  yh = (y0 < y1) ? y1 : y0;
        for (int r = yl; r <= yh; r++)
            for (int c = xl; c <= xh; c++) begin
                ec.push_back(c);
                er.push_back(r);
            end
        gb = got.size();
        db = done_cnt;
        in_write_available = 1'b1;
        start_fill(x0, y0, x1, y1, color, ovl);
        chk(out_busy == 1, {tag, "/busy_on"}, out_busy, 1);
        budget = n * (GAP + 1) * (rnd ? 8 : 1) + 50;
        for (int i = 0; i < budget && done_cnt == db; i++) begin
            in_write_available = rnd ? 1'($urandom) : 1'b1;
            if (i == inject) begin
                in_x0 = 0; in_y0 = 0; in_x1 = 63; in_y1 = 63;
                in_color = 8'h3C; in_start = 1'b1;
            end else begin
                in_start = 1'b0;
            end
            tick();
        end
        in_start = 1'b0;
        in_write_available = 1'b1;
        chk(done_cnt != db, {tag, "/timeout"}, done_cnt - db, 1);
        repeat (3) tick();
        chk(done_cnt - db == 1, {tag, "/done_cnt"}, done_cnt - db, 1);
        chk(out_busy == 0, {tag, "/busy_off"}, out_busy, 0);
        k = got.size() - gb;
        chk(k == n, {tag, "/count"}, k, n);
        chk(ec.size() == n, {tag, "/model_n"}, ec.size(), n);
        bad = -1;
        for (int i = 0; i < k && i < ec.size(); i++)
            if (bad < 0 && (got[gb+i].c != ec[i] || got[gb+i].r != er[i]))
                bad = i;
        chk(bad < 0, {tag, "/seq_idx"}, bad, -1);
        if (k > 0) begin
            chk(got[gb].c == fc && got[gb].r == fr, {tag, "/first"},
                got[gb].c * 64 + got[gb].r, fc * 64 + fr);
            chk(got[gb+k-1].c == lc && got[gb+k-1].r == lr, {tag, "/last"},
                got[gb+k-1].c * 64 + got[gb+k-1].r, lc * 64 + lr);
        end
        bad = -1;
        for (int i = 0; i < k; i++)
            if (bad < 0 && (got[gb+i].d != color || got[gb+i].o != ovl))
                bad = i;
        chk(bad < 0, {tag, "/payload_idx"}, bad, -1);
        bad = -1;
        for (int i = 1; i < k; i++) begin
            int sp;
            sp = got[gb+i].cyc - got[gb+i-1].cyc;
            if (bad < 0 && (rnd ? (sp < GAP + 1) : (sp != GAP + 1)))
                bad = i;
        end
        chk(bad < 0, {tag, "/spacing_idx"}, bad, -1);
        if (!rnd && k > 0)
            chk(done_cyc - got[gb+k-1].cyc == GAP + 1, {tag, "/done_lat"},
                done_cyc - got[gb+k-1].cyc, GAP + 1);
    endtask

    vec_t tbl[6];

    initial begin
        int gb, db, x0, y0, x1, y1, n;
        tbl[0] = '{2, 5, 4, 6, 'hA5, 0, 6, 2, 5, 4, 6};
        tbl[1] = '{4, 6, 2, 5, 'hA5, 0, 6, 2, 5, 4, 6};
        tbl[2] = '{10, 10, 10, 10, 'h11, 1, 1, 10, 10, 10, 10};
        tbl[3] = '{63, 0, 60, 2, 'hFF, 1, 12, 60, 0, 63, 2};
        tbl[4] = '{5, 63, 5, 60, 'h00, 0, 4, 5, 60, 5, 63};
        tbl[5] = '{0, 0, 63, 63, 'h5A, 1, 4096, 0, 0, 63, 63};

        rst = 1'b1;
        in_start = 0; in_abort = 0; in_write_available = 1;
        in_x0 = 0; in_y0 = 0; in_x1 = 0; in_y1 = 0;
        in_color = 0; in_overlay = 0;
        tick();
        tick();
        check_reset_outs("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++)
            run_fill(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1,
                     tbl[i].color, tbl[i].ovl, 1'b0, tbl[i].n,
                     tbl[i].fc, tbl[i].fr, tbl[i].lc, tbl[i].lr,
                     -1, $sformatf("vec%0d", i));

        // Start while busy must be ignored.
        run_fill(1, 1, 2, 2, 'h77, 1, 1'b0, 4, 1, 1, 2, 2, 2, "busy_start");

        // Stall on write_available for a 1x1 fill.
        gb = got.size();
        in_write_available = 1'b0;
        start_fill(10, 10, 10, 10, 'hC3, 0);
        repeat (20) tick();
        chk(got.size() == gb, "stall/no_write", got.size() - gb, 0);
        in_write_available = 1'b1;
        #1;
        chk(out_write == 1, "stall/write_now", out_write, 1);
        chk(out_column == 10 && out_row == 10, "stall/addr",
            out_column * 64 + out_row, 10 * 64 + 10);
        repeat (5) tick();
        chk(got.size() - gb == 1, "stall/count", got.size() - gb, 1);

        // Abort in GAP after third write of a 4x4 fill.
        gb = got.size();
        db = done_cnt;
        start_fill(0, 0, 3, 3, 'h99, 0);
        for (int i = 0; i < 40 && got.size() - gb < 3; i++) tick();
        chk(got.size() - gb == 3, "abort/reach3", got.size() - gb, 3);
        in_abort = 1'b1;
        tick();
        in_abort = 1'b0;
        chk(out_done == 1, "abort/done", out_done, 1);
        chk(out_busy == 1, "abort/busy_done", out_busy, 1);
        tick();
        chk(out_busy == 0, "abort/busy_off", out_busy, 0);
        repeat (10) tick();
        chk(got.size() - gb == 3, "abort/writes", got.size() - gb, 3);
        chk(done_cnt - db == 1, "abort/done_cnt", done_cnt - db, 1);

        // Reset mid-fill.
        db = done_cnt;
        start_fill(20, 30, 27, 37, 'hE7, 1);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        check_reset_outs("midrst");
        rst = 1'b0;
        gb = got.size();
        repeat (20) tick();
        chk(got.size() == gb, "midrst/no_write", got.size() - gb, 0);
        chk(done_cnt == db, "midrst/no_done", done_cnt - db, 0);

        // Random rectangles with random back-pressure.
        for (int t = 0; t < 8; t++) begin
            int xl, yl, xh, yh;
            x0 = $urandom_range(0, 63); y0 = $urandom_range(0, 63);
            x1 = $urandom_range(0, 63); y1 = $urandom_range(0, 63);
            if (t < 4) begin
                x1 = (x0 + $urandom_range(0, 9)) % 64;
                y1 = (y0 + $urandom_range(0, 9)) % 64;
            end
            xl = (x0 < x1) ? x0 : x1;  xh = (x0 < x1) ? x1 : x0;
            yl = (y0 < y1) ? y0 : y1;  yh = (y0 < y1) ? y1 : y0;
            n = (xh - xl + 1) * (yh - yl + 1);
            run_fill(x0, y0, x1, y1, $urandom_range(0, 255), t % 2,
                     1'b1, n, xl, yl, xh, yh, -1,
                     $sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
